mmio_arbiter: RTL

Two-master arbiter sharing the single `mmio` load/store port between the CPU data port (master 0) and a secondary bus master such as a VRAM blitter or DMA engine (master 1). It sits directly in front of `mmio`, drives its `load`/`store`/`access`/`addr`/`data_in` inputs, and captures `data_out` into a registered per-master read response. Masters use a request/grant handshake. With round-robin enabled, a burst limit bounds how long either master can hold the port.

---
 rtl/mmio_arb_pkg.sv | 32 +++
 rtl/mmio_arbiter_if.sv | 35 +++
 rtl/mmio_arb_rsp.sv | 29 ++
 rtl/mmio_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mmio_arb_pkg.sv
// Shared types and constants for the two-master mmio arbiter.
package mmio_arb_pkg;

  localparam int NUM_MST = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic [2:0] ACC_LB  = 3'b000;
  localparam logic [2:0] ACC_LW  = 3'b010;
  localparam logic [2:0] ACC_LBU = 3'b100;

  typedef logic mst_idx_t;

  // Request fields of one master, as presented to the arbiter.
  typedef struct packed {
    logic        load;
    logic        store;
    logic [2:0]  access;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mst_req_t;

  // Ownership state for a given master index.
  function automatic arb_state_e own_state(mst_idx_t m);
    return m ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/mmio_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the mmio block.
interface mmio_arbiter_if;
  logic        m0_req,    m1_req;
  logic        m0_load,   m1_load;
  logic        m0_store,  m1_store;
  logic [2:0]  m0_access, m1_access;
  logic [31:0] m0_addr,   m1_addr;
  logic [31:0] m0_wdata,  m1_wdata;
  logic        m0_gnt,    m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata,  m1_rdata;
  logic        load, store;
  logic [2:0]  access;
  logic [31:0] addr, data_in;
  logic [31:0] data_out;
  logic        busy;

  // Arbiter side.
  modport slave (
    input  m0_req, m1_req, m0_load, m1_load, m0_store, m1_store,
           m0_access, m1_access, m0_addr, m1_addr, m0_wdata, m1_wdata,
           data_out,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           load, store, access, addr, data_in, busy
  );

  // Masters plus mmio read data, as seen from outside the arbiter.
  modport master (
    output m0_req, m1_req, m0_load, m1_load, m0_store, m1_store,
           m0_access, m1_access, m0_addr, m1_addr, m0_wdata, m1_wdata,
           data_out,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           load, store, access, addr, data_in, busy
  );
endinterface

// File: rtl/mmio_arb_rsp.sv
// Per-master load response register: captures mmio read data on an
// accepted load and pulses rvalid for the following cycle.
module mmio_arb_rsp (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cap,
  input  logic [31:0] i_data,
  output logic        o_rvalid,
  output logic [31:0] o_rdata
);

  logic        r_rvalid;
  logic [31:0] r_rdata;

  // Capture on accepted load; rdata holds across stores and idle cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= i_cap;
      if (i_cap) r_rdata <= i_data;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;

endmodule

// File: rtl/mmio_arbiter.sv
// Two-master arbiter in front of mmio. Master 0 is the CPU data port,
// master 1 a secondary bus master. Define MMIO_ARB_RR_EN for round-robin
// with a MAX_BURST tenure limit; otherwise master 0 has fixed priority.
module mmio_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  mmio_arbiter_if.slave bus
);

  arb_state_e                r_state, w_state_nxt;
  logic [NUM_MST-1:0]        w_req, w_gnt, w_acc, w_rvalid;
  logic [NUM_MST-1:0][31:0]  w_rdata;
  mst_req_t [NUM_MST-1:0]    w_fld;
  mst_idx_t                  w_own, w_oth;
  logic                      w_busy, w_load, w_store;
  logic [2:0]                w_access;
  logic [31:0]               w_addr, w_data_in;

  assign w_req    = {bus.m1_req, bus.m0_req};
  assign w_fld[0] = {bus.m0_load, bus.m0_store, bus.m0_access, bus.m0_addr, bus.m0_wdata};
  assign w_fld[1] = {bus.m1_load, bus.m1_store, bus.m1_access, bus.m1_addr, bus.m1_wdata};
  assign w_own    = (r_state == OWN1);
  assign w_oth    = ~w_own;
  assign w_acc    = w_req & w_gnt;

`ifdef MMIO_ARB_RR_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic [CNT_W-1:0] r_burst_cnt, w_cnt_post;
  mst_idx_t         r_last_owner;

  // Saturating count of transfers made in the current tenure.
  always_comb begin
    w_cnt_post = r_burst_cnt;
    if (|w_acc && r_burst_cnt < MAX_CNT) w_cnt_post = r_burst_cnt + CNT_W'(1);
  end

  // Tenure counter and last owner; last_owner starts at 1 so master 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_burst_cnt  <= '0;
      r_last_owner <= 1'b1;
    end else begin
      r_burst_cnt <= (w_state_nxt != r_state) ? '0 : w_cnt_post;
      if (w_state_nxt != r_state && w_state_nxt != IDLE)
        r_last_owner <= (w_state_nxt == OWN1);
    end
  end

  // Next state: round-robin on contention, yield after MAX_BURST transfers.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_req[0] && w_req[1]) w_state_nxt = own_state(~r_last_owner);
        else if (w_req[0])        w_state_nxt = OWN0;
        else if (w_req[1])        w_state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (!w_req[w_own])
          w_state_nxt = w_req[w_oth] ? own_state(w_oth) : IDLE;
        else if (w_cnt_post >= MAX_CNT && w_req[w_oth])
          w_state_nxt = own_state(w_oth);
      end
      default: w_state_nxt = IDLE;
    endcase
  end
`else
  // Next state: master 0 always wins; master 1 is preempted after its current cycle.
  always_comb begin
    w_state_nxt = IDLE;
    if (w_req[0])      w_state_nxt = OWN0;
    else if (w_req[1]) w_state_nxt = OWN1;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Grants and busy decoded from state only.
  always_comb begin
    w_gnt  = '0;
    w_busy = (r_state != IDLE);
    case (r_state)
      OWN0:    w_gnt[0] = 1'b1;
      OWN1:    w_gnt[1] = 1'b1;
      default: w_gnt    = '0;
    endcase
  end

  // Downstream mux: zero unless the owner is transferring; store beats load.
  always_comb begin
    w_load    = 1'b0;
    w_store   = 1'b0;
    w_access  = '0;
    w_addr    = '0;
    w_data_in = '0;
    if (|w_acc) begin
      w_store   = w_fld[w_own].store;
      w_load    = w_fld[w_own].load & ~w_fld[w_own].store;
      w_access  = w_fld[w_own].access;
      w_addr    = w_fld[w_own].addr;
      w_data_in = w_fld[w_own].wdata;
    end
  end

  for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_rsp
    mmio_arb_rsp u_rsp (
      .clk      (clk),
      .rst      (rst),
      .i_cap    (w_acc[gi] & w_load),
      .i_data   (bus.data_out),
      .o_rvalid (w_rvalid[gi]),
      .o_rdata  (w_rdata[gi])
    );
  end

  assign bus.m0_gnt    = w_gnt[0];
  assign bus.m1_gnt    = w_gnt[1];
  assign bus.m0_rvalid = w_rvalid[0];
  assign bus.m1_rvalid = w_rvalid[1];
  assign bus.m0_rdata  = w_rdata[0];
  assign bus.m1_rdata  = w_rdata[1];
  assign bus.load      = w_load;
  assign bus.store     = w_store;
  assign bus.access    = w_access;
  assign bus.addr      = w_addr;
  assign bus.data_in   = w_data_in;
  assign bus.busy      = w_busy;

endmodule
